udp_stack_axil_regfile: RTL and testbench
=========================================

# udp_stack_axil_regfile

Parametrised AXI4-Lite slave register file for the Ethernet/ARP/UDP stack. It replaces the fixed four-register slave with:

- configurable register count and data width;
- byte-strobe writes;
- read-only status registers;
- a write-1-to-clear interrupt register;
- SLVERR reporting.

It sits between the PS AXI interconnect and the stack's control/status logic.

## Interface
- DATA_WIDTH, 32 — AXI data width; 32 or 64 only.
- ADDR_WIDTH, 8 — AXI byte-address width.
- NUM_RW, 4 — number of read/write control registers; ≥1.
- NUM_RO, 2 — number of read-only status registers; ≥0.
- IRQ_WIDTH, 8 — interrupt source count; ≤ DATA_WIDTH.

Ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- ctrl_o  out  NUM_RW*DATA_WIDTH  RW register contents; register k occupies slice k.
- status_i  in  NUM_RO*DATA_WIDTH  RO register values, sampled at read.
- irq_src_i  in  IRQ_WIDTH  single-cycle interrupt set pulses.
- irq_o  out  1  level interrupt: OR of (IRQ_STATUS & IRQ_ENABLE).

## Operation

Address decode:
- Register index = ADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low address bits are ignored.

Register map:
- Indices 0..NUM_RW-1: RW control registers.
- Next NUM_RO indices: RO status registers.
- Index NUM_RW+NUM_RO: IRQ_STATUS (W1C).
- Index NUM_RW+NUM_RO+1: IRQ_ENABLE (RW).
- Any higher index is out of range.

Write channel:
- AW and W are captured independently into holding registers and may arrive in either order or in the same cycle.
- AWREADY is high while no address is held and BVALID is low; WREADY likewise for data.
- Once both are held, the write is performed and BVALID is asserted.
- Write FSM states:
  - W_IDLE → W_HAVE_ADDR or W_HAVE_DATA → W_RESP.
  - W_IDLE → W_RESP directly when both channels handshake together.
  - W_RESP → W_IDLE on BVALID & BREADY.
- Strobes: byte b updates only when WSTRB[b]=1. A write with WSTRB=0 is OKAY and changes nothing.
- IRQ_STATUS: each written 1 (under strobe) clears the bit.
- Writes to RO or out-of-range indices return BRESP=SLVERR (2'b10) and modify nothing. All other writes return OKAY.

Read channel:
- Read FSM states: R_IDLE (ARREADY=1) → R_RESP on ARVALID.
- R_RESP holds RDATA/RRESP/RVALID stable until RREADY, then returns to R_IDLE.
- An out-of-range read returns RDATA=0 with SLVERR.
- Unused upper bits of IRQ registers read as 0.

Interrupts:
- irq_src_i[n]=1 sets IRQ_STATUS[n].
- If a set pulse and a W1C clear hit the same bit in the same cycle, the set wins.

## Timing

Reset:
- While ARESET is high: AWREADY, WREADY, ARREADY, BVALID and RVALID are 0; BRESP, RRESP and RDATA are 0; ctrl_o, IRQ_STATUS, IRQ_ENABLE and irq_o are 0.
- Ready signals go high on the first edge after ARESET is released.
- Asserting ARESET mid-transaction abandons it. No response is issued and holding registers clear.

Latency:
- Write: last of the AW/W handshakes on edge N → register, ctrl_o and BVALID updated at N+1.
- Read: AR handshake on edge N → RVALID with data at N+1.
- status_i is sampled on the AR handshake edge.

Other timing rules:
- irq_o is derived combinationally from registered state. It rises one cycle after the irq_src_i pulse edge.
- The write and read paths are fully independent. A simultaneous write and read of the same register returns the old value.
- Maximum throughput is one transaction per two cycles per channel. No outstanding transactions beyond one.

## Structure
- Package udp_stack_axil_pkg:
  - RESP_OKAY and RESP_SLVERR constants;
  - write/read FSM state enums;
  - a strobe-merge function (old data, new data, strobe).
- Single module; no sub-module is warranted.

## Test plan
1. Write 0x1..0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read them back → RDATA=0x1..0x4, all responses OKAY, ctrl_o slices match.
2. Write 0xAABBCCDD then 0x11223344 with WSTRB=4'b0101 to reg 0 → reads back 0xAA22CC44.
3. Present W two cycles before AW, and hold BREADY low for 3 cycles → one write only; BVALID stays high until BREADY; AWREADY/WREADY stay low meanwhile.
4. Read address 0xFC, then write an RO register → RRESP=SLVERR with RDATA=0; BRESP=SLVERR; RO value unchanged.
5. Pulse irq_src_i[2] with IRQ_ENABLE=0x4 → irq_o=1. Then write 0x4 to IRQ_STATUS while pulsing irq_src_i[2] in the same cycle → bit stays set. A later W1C clears it → irq_o=0.
6. Assert ARESET while BVALID is pending → BVALID=0 and ctrl_o=0 immediately. Ready signals return 1 cycle after release.

Source files
------------

// File: rtl/udp_stack_axil_pkg.sv
// rtl/udp_stack_axil_pkg.sv - shared constants, FSM states and strobe helper for the AXI-Lite register file
//
// Purpose: response codes, write/read channel FSM state encodings and the
// byte-strobe merge used by every writable register.

package udp_stack_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Sized for the widest supported bus (64 bits / 8 strobes); narrower
    // callers zero-extend their operands and keep the low bits.
    function automatic logic [63:0] strb_merge(
        input logic [63:0] old_data,
        input logic [63:0] new_data,
        input logic [7:0]  strb
    );
        logic [63:0] merged;
        merged = old_data;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/udp_stack_axil_regfile.sv
// rtl/udp_stack_axil_regfile.sv - AXI4-Lite slave register file for the Ethernet/ARP/UDP stack
//
// Purpose: NUM_RW control registers, NUM_RO read-only status registers, a
// write-1-to-clear interrupt status register and an interrupt enable register.
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*         write address / data / response channels
//   S_AXI_AR*/R*            read address / data channels
//   ctrl_o                  control register contents, register k in slice k
//   status_i                status register values, sampled on the AR handshake
//   irq_src_i               single-cycle interrupt set pulses
//   irq_o                   OR of enabled pending interrupts

module udp_stack_axil_regfile
    import udp_stack_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_RW     = 4,
    parameter int NUM_RO     = 2,
    parameter int IRQ_WIDTH  = 8
) (
    input  logic                                           ACLK,
    input  logic                                           ARESET,
    input  logic [ADDR_WIDTH-1:0]                          S_AXI_AWADDR,
    input  logic [2:0]                                     S_AXI_AWPROT,
    input  logic                                           S_AXI_AWVALID,
    output logic                                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                        S_AXI_WSTRB,
    input  logic                                           S_AXI_WVALID,
    output logic                                           S_AXI_WREADY,
    output logic [1:0]                                     S_AXI_BRESP,
    output logic                                           S_AXI_BVALID,
    input  logic                                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                          S_AXI_ARADDR,
    input  logic [2:0]                                     S_AXI_ARPROT,
    input  logic                                           S_AXI_ARVALID,
    output logic                                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                          S_AXI_RDATA,
    output logic [1:0]                                     S_AXI_RRESP,
    output logic                                           S_AXI_RVALID,
    input  logic                                           S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0]                   ctrl_o,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_i,
    input  logic [IRQ_WIDTH-1:0]                           irq_src_i,
    output logic                                           irq_o
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int IDX_LSB    = $clog2(STRB_W);
    localparam int IDX_W      = ADDR_WIDTH - IDX_LSB;
    localparam int IRQ_ST_IDX = NUM_RW + NUM_RO;
    localparam int IRQ_EN_IDX = NUM_RW + NUM_RO + 1;

    // Held low through reset and set on the first edge after release, so the
    // ready outputs stay low while ARESET is asserted.
    logic                  ready_en;

    wr_state_t             wstate;
    rd_state_t             rstate;

    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic [DATA_WIDTH-1:0] ctrl_q [NUM_RW];
    logic [IRQ_WIDTH-1:0]  irq_status_q;
    logic [IRQ_WIDTH-1:0]  irq_enable_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  do_write;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [63:0]           mask64;
    logic [DATA_WIDTH-1:0] wr_bmask;
    logic                  wr_is_rw;
    logic                  wr_is_st;
    logic                  wr_is_en;
    logic [IRQ_WIDTH-1:0]  irq_clear;

    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    logic                  unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[IDX_LSB-1:0],
                           S_AXI_ARADDR[IDX_LSB-1:0], mask64};

    // ---------------------------------------------------------------- write

    assign S_AXI_AWREADY = ready_en && (wstate == W_IDLE || wstate == W_HAVE_DATA);
    assign S_AXI_WREADY  = ready_en && (wstate == W_IDLE || wstate == W_HAVE_ADDR);
    assign S_AXI_BVALID  = (wstate == W_RESP);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

    // A channel that handshakes this cycle bypasses its holding register so
    // the write lands on the edge of the last handshake.
    assign wr_idx  = aw_hs ? S_AXI_AWADDR[ADDR_WIDTH-1:IDX_LSB] : aw_idx_q;
    assign wr_data = w_hs ? S_AXI_WDATA : w_data_q;
    assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb_q;

    assign do_write = (wstate != W_RESP)
                   && (aw_hs || wstate == W_HAVE_ADDR)
                   && (w_hs  || wstate == W_HAVE_DATA);

    assign wr_is_rw = (wr_idx < IDX_W'(NUM_RW));
    assign wr_is_st = (wr_idx == IDX_W'(IRQ_ST_IDX));
    assign wr_is_en = (wr_idx == IDX_W'(IRQ_EN_IDX));

    always_comb begin
        mask64   = strb_merge(64'd0, {64{1'b1}}, 8'(wr_strb));
        wr_bmask = mask64[DATA_WIDTH-1:0];
    end

    assign irq_clear = (do_write && wr_is_st)
                     ? (wr_data[IRQ_WIDTH-1:0] & wr_bmask[IRQ_WIDTH-1:0])
                     : '0;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate      <= W_IDLE;
            aw_idx_q    <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            S_AXI_BRESP <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wstate <= W_RESP;
                    end else if (aw_hs) begin
                        wstate <= W_HAVE_ADDR;
                    end else if (w_hs) begin
                        wstate <= W_HAVE_DATA;
                    end
                end
                W_HAVE_ADDR: if (w_hs)  wstate <= W_RESP;
                W_HAVE_DATA: if (aw_hs) wstate <= W_RESP;
                W_RESP:      if (S_AXI_BREADY) wstate <= W_IDLE;
                default:     wstate <= W_IDLE;
            endcase

            if (aw_hs) begin
                aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:IDX_LSB];
            end
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (do_write) begin
                S_AXI_BRESP <= (wr_is_rw || wr_is_st || wr_is_en) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_RW; k++) begin
                ctrl_q[k] <= '0;
            end
            irq_status_q <= '0;
            irq_enable_q <= '0;
        end else begin
            for (int k = 0; k < NUM_RW; k++) begin
                if (do_write && wr_idx == IDX_W'(k)) begin
                    ctrl_q[k] <= (ctrl_q[k] & ~wr_bmask) | (wr_data & wr_bmask);
                end
            end
            if (do_write && wr_is_en) begin
                irq_enable_q <= (irq_enable_q & ~wr_bmask[IRQ_WIDTH-1:0])
                              | (wr_data[IRQ_WIDTH-1:0] & wr_bmask[IRQ_WIDTH-1:0]);
            end
            // Set is applied after clear so a simultaneous pulse wins.
            irq_status_q <= (irq_status_q & ~irq_clear) | irq_src_i;
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
    end

    assign irq_o = |(irq_status_q & irq_enable_q);

    // ----------------------------------------------------------------- read

    assign S_AXI_ARREADY = ready_en && (rstate == R_IDLE);
    assign S_AXI_RVALID  = (rstate == R_RESP);
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_idx        = S_AXI_ARADDR[ADDR_WIDTH-1:IDX_LSB];

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
            if (ar_idx == IDX_W'(k)) begin
                rd_data = ctrl_q[k];
                rd_resp = RESP_OKAY;
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (ar_idx == IDX_W'(NUM_RW + k)) begin
                rd_data = status_i[k*DATA_WIDTH +: DATA_WIDTH];
                rd_resp = RESP_OKAY;
            end
        end
        if (ar_idx == IDX_W'(IRQ_ST_IDX)) begin
            rd_data = DATA_WIDTH'(irq_status_q);
            rd_resp = RESP_OKAY;
        end
        if (ar_idx == IDX_W'(IRQ_EN_IDX)) begin
            rd_data = DATA_WIDTH'(irq_enable_q);
            rd_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate      <= R_IDLE;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate      <= R_RESP;
                        S_AXI_RDATA <= rd_data;
                        S_AXI_RRESP <= rd_resp;
                    end
                end
                R_RESP:  if (S_AXI_RREADY) rstate <= R_IDLE;
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_stack_axil_regfile.sv
// tb/tb_udp_stack_axil_regfile.sv - self-checking bench for the AXI-Lite register file

module tb_udp_stack_axil_regfile;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NRW = 4;
    localparam int NRO = 2;
    localparam int IW  = 8;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NRW*DW-1:0] ctrl;
    logic [NRO*DW-1:0] status;
    logic [IW-1:0]     irq_src;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    udp_stack_axil_regfile #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO), .IRQ_WIDTH(IW)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_o(ctrl), .status_i(status), .irq_src_i(irq_src), .irq_o(irq)
    );

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic set_vec(input int i, input bit w, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] e, input logic [1:0] r);
        vecs[i] = '{is_wr: w, addr: a, data: d, strb: s, exp_data: e, exp_resp: r};
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int  n;
        bit  aw_go;
        bit  w_go;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge clk);
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            timeout("write_addr_data");
            awvalid = 1'b0; wvalid = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            timeout("write_resp");
            resp = 2'b11;
        end else begin
            resp = bresp;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit go;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        go = 1'b0;
        while (!go && n < 20) begin
            go = arready;
            @(negedge clk);
            n++;
        end
        arvalid = 1'b0;
        if (!go) timeout("read_addr");
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            timeout("read_data");
            d = 'x; resp = 2'b11;
        end else begin
            d = rdata; resp = rresp;
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] held;

        rst = 1'b1;
        awaddr = '0; awprot = 3'b010; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = 3'b101; arvalid = 1'b0; rready = 1'b0;
        irq_src = '0;
        status = {32'h5151_0002, 32'hA0A0_0001};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_readies", {awready, wready, arready}, 3'b000);
        chk("rst_valids", {bvalid, rvalid}, 2'b00);
        chk("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        chk("rst_ctrl_irq", {ctrl, irq}, '0);
        rst = 1'b0;
        #1;
        chk("rel_readies_low", {awready, wready, arready}, 3'b000);
        @(posedge clk);
        #1;
        chk("rel_readies_high", {awready, wready, arready}, 3'b111);

        // Table-driven vectors
        set_vec(0,  1, 8'h00, 32'h1,         4'hF, 32'h0,         OK);
        set_vec(1,  1, 8'h04, 32'h2,         4'hF, 32'h0,         OK);
        set_vec(2,  1, 8'h08, 32'h3,         4'hF, 32'h0,         OK);
        set_vec(3,  1, 8'h0C, 32'h4,         4'hF, 32'h0,         OK);
        set_vec(4,  0, 8'h00, 32'h0,         4'h0, 32'h1,         OK);
        set_vec(5,  0, 8'h04, 32'h0,         4'h0, 32'h2,         OK);
        set_vec(6,  0, 8'h08, 32'h0,         4'h0, 32'h3,         OK);
        set_vec(7,  0, 8'h0C, 32'h0,         4'h0, 32'h4,         OK);
        set_vec(8,  1, 8'h00, 32'hAABBCCDD,  4'hF, 32'h0,         OK);
        set_vec(9,  1, 8'h00, 32'h11223344,  4'h5, 32'h0,         OK);
        set_vec(10, 0, 8'h00, 32'h0,         4'h0, 32'hAA22CC44,  OK);
        set_vec(11, 1, 8'h04, 32'hFFFFFFFF,  4'h0, 32'h0,         OK);
        set_vec(12, 0, 8'h04, 32'h0,         4'h0, 32'h2,         OK);
        set_vec(13, 0, 8'h10, 32'h0,         4'h0, 32'hA0A00001,  OK);
        set_vec(14, 0, 8'h14, 32'h0,         4'h0, 32'h51510002,  OK);
        set_vec(15, 1, 8'h10, 32'hDEADBEEF,  4'hF, 32'h0,         ERR);
        set_vec(16, 0, 8'h10, 32'h0,         4'h0, 32'hA0A00001,  OK);
        set_vec(17, 0, 8'hFC, 32'h0,         4'h0, 32'h0,         ERR);
        set_vec(18, 1, 8'hFC, 32'h12345678,  4'hF, 32'h0,         ERR);
        set_vec(19, 0, 8'h1C, 32'h0,         4'h0, 32'h0,         OK);
        set_vec(20, 1, 8'h1C, 32'hFFFFFF04,  4'hF, 32'h0,         OK);
        set_vec(21, 0, 8'h1C, 32'h0,         4'h0, 32'h4,         OK);
        set_vec(22, 0, 8'h0E, 32'h0,         4'h0, 32'h4,         OK);
        set_vec(23, 0, 8'h18, 32'h0,         4'h0, 32'h0,         OK);
        set_vec(24, 1, 8'h20, 32'h1,         4'hF, 32'h0,         ERR);
        set_vec(25, 0, 8'h20, 32'h0,         4'h0, 32'h0,         ERR);
        set_vec(26, 1, 8'h0D, 32'h0000AB00,  4'h2, 32'h0,         OK);
        set_vec(27, 0, 8'h0C, 32'h0,         4'h0, 32'h0000AB04,  OK);

        for (int i = 0; i < 28; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                chk($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
            end
        end
        chk("ctrl_after_table", ctrl, {32'h0000AB04, 32'h3, 32'h2, 32'hAA22CC44});

        // W two cycles ahead of AW, BREADY held low for three cycles
        @(negedge clk);
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        chk("wfirst_wready_low", wready, 1'b0);
        chk("wfirst_awready_high", awready, 1'b1);
        chk("wfirst_no_bvalid", bvalid, 1'b0);
        @(negedge clk);
        awaddr = 8'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("wfirst_bvalid", bvalid, 1'b1);
        chk("wfirst_ctrl2", ctrl[95:64], 32'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bhold%0d_valid_readies", i), {bvalid, awready, wready}, 3'b100);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bhold_released", {bvalid, awready, wready}, 3'b011);
        chk("wfirst_single_write", ctrl, {32'h0000AB04, 32'h55, 32'h2, 32'hAA22CC44});

        // RDATA held stable while RREADY is low
        @(negedge clk);
        araddr = 8'h08; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("rhold_first", {rvalid, rdata, rresp}, {1'b1, 32'h55, OK});
        held = rdata;
        repeat (2) @(negedge clk);
        chk("rhold_stable", {rvalid, rdata, arready}, {1'b1, held, 1'b0});
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rhold_done", {rvalid, arready}, 2'b01);

        // Interrupts: IRQ_ENABLE = 0x04 from the table
        chk("irq_idle", irq, 1'b0);
        @(negedge clk);
        irq_src = 8'h04;
        @(negedge clk);
        irq_src = 8'h00;
        chk("irq_set", irq, 1'b1);
        @(negedge clk);
        irq_src = 8'h08;
        @(negedge clk);
        irq_src = 8'h00;
        axi_read(8'h18, d, r);
        chk("irq_status_0c", d, 32'h0C);
        // W1C of bit 2 coincident with a set pulse on bit 2
        @(negedge clk);
        awaddr = 8'h18; wdata = 32'h4; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0; irq_src = 8'h04;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; irq_src = 8'h00;
        chk("w1c_race_resp", {bvalid, bresp}, {1'b1, OK});
        chk("w1c_race_irq", irq, 1'b1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(8'h18, d, r);
        chk("w1c_race_status", d, 32'h0C);
        axi_write(8'h18, 32'h4, 4'hF, r);
        chk("w1c_resp", r, OK);
        chk("w1c_irq_low", irq, 1'b0);
        axi_read(8'h18, d, r);
        chk("w1c_status", d, 32'h08);

        // Reset while BVALID is pending
        @(negedge clk);
        awaddr = 8'h04; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("pre_rst_pending", {bvalid, ctrl[63:32]}, {1'b1, 32'h77});
        rst = 1'b1;
        #1;
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_ctrl", ctrl, '0);
        chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_readies_low", {awready, wready, arready, bvalid}, 4'b0000);
        @(posedge clk);
        #1;
        chk("mid_rel_readies_high", {awready, wready, arready, bvalid}, 4'b1110);
        axi_read(8'h1C, d, r);
        chk("post_rst_irq_en", {d, r}, {32'h0, OK});
        axi_write(8'h00, 32'h9, 4'hF, r);
        axi_read(8'h00, d, r);
        chk("post_rst_rw", {d, r}, {32'h9, OK});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
